// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery constant generator.
//   state_t : controller states, also exported on the debug state port
//   MODE_R  : compute R mod n only
//   MODE_RR : compute R mod n followed by R^2 mod n
package mont_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC_R  = 3'd1,
    CALC_R2 = 3'd2,
    FIN     = 3'd3,
    FAIL    = 3'd4
  } state_t;

  localparam logic MODE_R  = 1'b0;
  localparam logic MODE_RR = 1'b1;

endpackage

// File: rtl/mod_dbl_step.sv
// One modular doubling: y = 2x mod n, valid when x < n.
// Ports:
//   x : current residue (must be below n)
//   n : modulus
//   y : doubled residue, again below n
module mod_dbl_step #(
  parameter int WIDTH = 4096
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] y
);

  // 2x needs one extra bit; since x < n, 2x - n < n so the difference fits WIDTH.
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] diff;

  assign dbl  = {x, 1'b0};
  assign diff = dbl - {1'b0, n};
  assign y    = (dbl >= {1'b0, n}) ? diff[WIDTH-1:0] : dbl[WIDTH-1:0];

endmodule

// File: rtl/mont_const_gen.sv
// Generates R mod n and (optionally) R^2 mod n, R = 2^WIDTH, for odd n >= 3,
// by repeated modular doubling starting from x = 1. STEPS doublings are
// chained combinationally each clock.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   go         : start request, only looked at in IDLE
//   mode       : MODE_R = R only, MODE_RR = R and R^2 (sampled with go)
//   n          : modulus, captured with go
//   r, r2      : results (r2 meaningful only for MODE_RR)
//   busy       : computation in progress
//   done       : level, high from completion until the next accepted go
//   err        : level, high with done when the modulus was rejected
//   dbg_state  : current controller state
//
// Handshake: a go seen while the controller is in IDLE is accepted on that
// edge (even if done is still high); go at any other time is ignored. Results
// are stable while done is high.
module mont_const_gen
  import mont_pkg::*;
#(
  parameter int WIDTH = 4096,
  parameter int STEPS = 1,
  parameter int CW    = $clog2(2*WIDTH/STEPS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             mode,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output state_t           dbg_state
);

  if ((WIDTH % STEPS) != 0) begin : g_bad_steps
    $error("mont_const_gen: STEPS must divide WIDTH");
  end

  localparam logic [CW-1:0] ITER      = CW'(WIDTH / STEPS);
  localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH / STEPS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] n_q;
  logic             mode_q;
  logic             n_bad;
  logic [WIDTH-1:0] stage [STEPS+1];

  assign n_bad     = !n[0] || (n < WIDTH'(3));
  assign dbg_state = state;

  assign stage[0] = x;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    mod_dbl_step #(.WIDTH(WIDTH)) u_step (
      .x (stage[i]),
      .n (n_q),
      .y (stage[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = n_bad ? FAIL : CALC_R;
      CALC_R:  if (cnt == ITER_LAST) state_nxt = (mode_q == MODE_RR) ? CALC_R2 : FIN;
      // CALC_R2 spends one extra cycle (cnt == ITER) to register r2.
      CALC_R2: if (cnt == ITER) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      x      <= '0;
      n_q    <= '0;
      mode_q <= MODE_R;
      r      <= '0;
      r2     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            n_q    <= n;
            mode_q <= mode;
            r      <= '0;
            r2     <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            cnt    <= '0;
            x      <= n_bad ? '0 : WIDTH'(1);
          end
        end
        CALC_R: begin
          x <= stage[STEPS];
          if (cnt == ITER_LAST) begin
            r   <= stage[STEPS];
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CALC_R2: begin
          if (cnt == ITER) begin
            r2 <= x;
          end else begin
            x   <= stage[STEPS];
            cnt <= cnt + CW'(1);
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        FAIL: begin
          err  <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          r    <= '0;
          r2   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
